// File: rtl/pipe_elastic_pkg.sv
// Shared types and helpers for the elastic pipeline and its skid stages.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  function automatic int occ_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/pipe_elastic_if.sv
// Upstream and downstream valid/ready stream signals of the elastic pipeline.
interface pipe_elastic_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/pipe_elastic_skid_stage.sv
// One full-throughput skid stage: main register drives the output, skid register
// absorbs the word that arrives while the downstream is stalled.
module skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  stage_state_t      state_reg, state_next;
  logic [DATA_W-1:0] main_reg, skid_reg;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) state_reg <= EMPTY;
    else                 state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      EMPTY: if (in_fire) state_next = BUSY;
      BUSY: begin
        if (in_fire && !out_fire)      state_next = FULL;
        else if (!in_fire && out_fire) state_next = EMPTY;
      end
      FULL:    if (out_fire) state_next = BUSY;
      default: state_next = EMPTY;
    endcase
  end

  // in_ready depends only on registered state, which cuts the ready chain here.
  always_comb begin
    in_ready  = (state_reg != FULL);
    out_valid = (state_reg != EMPTY);
    out_data  = main_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_reg <= '0;
      skid_reg <= '0;
    end else if (state_reg == FULL) begin
      if (out_fire) main_reg <= skid_reg;
    end else if (in_fire) begin
      if (state_reg == EMPTY || out_fire) main_reg <= in_data;
      else                                skid_reg <= in_data;
    end
  end

endmodule

// File: rtl/pipe_elastic.sv
// Elastic pipeline: a chain of STAGES skid stages with occupancy count and flush.
module pipe_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = occ_width(STAGES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  pipe_elastic_if.slave    bus,
  output logic [CNT_W-1:0] occupancy
);

  logic [DATA_W-1:0] data [STAGES+1];
  logic [STAGES:0]   valid;
  logic [STAGES:0]   ready;
  logic              in_fire, out_fire;
  logic [CNT_W-1:0]  occ_reg;

  // Input is refused entirely during reset and flush, not just discarded.
  assign data[0]  = bus.in_data;
  assign valid[0] = bus.in_valid & rst_n & ~flush;
  assign ready[STAGES] = bus.out_ready;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      skid_stage #(.DATA_W(DATA_W)) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (data[gi]),
        .in_valid  (valid[gi]),
        .in_ready  (ready[gi]),
        .out_data  (data[gi+1]),
        .out_valid (valid[gi+1]),
        .out_ready (ready[gi+1])
      );
    end
  endgenerate

  assign bus.in_ready  = ready[0] & rst_n & ~flush;
  assign bus.out_data  = data[STAGES];
  assign bus.out_valid = valid[STAGES];

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = valid[STAGES] & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      occ_reg <= '0;
    end else begin
      unique case ({in_fire, out_fire})
        2'b10:   occ_reg <= occ_reg + CNT_W'(1);
        2'b01:   occ_reg <= occ_reg - CNT_W'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  assign occupancy = occ_reg;

endmodule
